// File: rtl/gfx_pkg.sv
// Shared graphics definitions: sprite DMA state encoding and ROM timing.
package gfx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        GRANT = 3'd2,
        READ  = 3'd3,
        END   = 3'd4
    } sprite_dma_state_t;

    localparam int ROM_LAT = 1;

    // A single-entry slot counter still needs one bit.
    function automatic int slot_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_dma_hold.sv
// Per-sprite line-data hold registers with a bypass of the live ROM word
// onto the slot that is currently being read.
module sprite_dma_hold
    import gfx_pkg::*;
#(
    parameter int NSPR  = 4,
    parameter int WIDTH = 8,
    parameter int SLOTW = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [SLOTW-1:0]      slot,
    input  logic [WIDTH-1:0]      rom_data,
    output logic [NSPR*WIDTH-1:0] data_out
);

    logic [NSPR-1:0][WIDTH-1:0] hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold <= '0;
        end else if (load) begin
            hold[slot] <= rom_data;
        end
    end

    // The engine samples during the read cycle, so it sees rom_data directly.
    always_comb begin
        data_out = hold;
        if (load) begin
            data_out[slot*WIDTH +: WIDTH] = rom_data;
        end
    end

endmodule

// File: rtl/sprite_dma.sv
// Blanking-interval DMA that walks the enabled sprites, fetches one ROM line
// word per sprite and hands it to that sprite's engine.
module sprite_dma
    import gfx_pkg::*;
#(
    parameter int NSPR  = 4,
    parameter int WIDTH = 8,
    parameter int ADDRW = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line_start,
    input  logic                  window,
    input  logic [NSPR-1:0]       enable,
    input  logic [NSPR*ADDRW-1:0] base,
    input  logic [NSPR*ADDRW-1:0] pos,
    output logic [ADDRW-1:0]      rom_addr,
    input  logic [WIDTH-1:0]      rom_data,
    output logic [NSPR-1:0]       dma_avail,
    output logic [NSPR*WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_state
);

    localparam int SLOTW = slot_width(NSPR);
    localparam logic [SLOTW-1:0] LAST_SLOT = SLOTW'(NSPR - 1);

    sprite_dma_state_t state, state_d;
    logic [SLOTW-1:0]  slot, slot_d;
    logic [NSPR-1:0]   mask, mask_d;
    logic [ADDRW-1:0]  base_sel, pos_sel;
    logic              load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            slot  <= '0;
            mask  <= '0;
        end else begin
            state <= state_d;
            slot  <= slot_d;
            mask  <= mask_d;
        end
    end

    // A window drop during GRANT still lets READ finish; READ then ends the line.
    always_comb begin
        state_d = state;
        slot_d  = slot;
        mask_d  = mask;
        case (state)
            IDLE: begin
                if (line_start && window) begin
                    mask_d  = enable;
                    slot_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!window) begin
                    state_d = END;
                end else if (mask[slot]) begin
                    state_d = GRANT;
                end else if (slot == LAST_SLOT) begin
                    state_d = END;
                end else begin
                    slot_d = slot + 1'b1;
                end
            end
            GRANT: state_d = READ;
            READ: begin
                if (slot == LAST_SLOT || !window) begin
                    state_d = END;
                end else begin
                    slot_d  = slot + 1'b1;
                    state_d = SCAN;
                end
            end
            END:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign base_sel = base[slot*ADDRW +: ADDRW];
    assign pos_sel  = pos[slot*ADDRW +: ADDRW];

    always_comb begin
        dma_avail = '0;
        rom_addr  = '0;
        if (state == GRANT) begin
            dma_avail[slot] = 1'b1;
            rom_addr        = base_sel + pos_sel;
        end
        load      = (state == READ);
        busy      = (state != IDLE);
        done      = (state == END);
        dbg_state = state;
    end

    sprite_dma_hold #(
        .NSPR  (NSPR),
        .WIDTH (WIDTH),
        .SLOTW (SLOTW)
    ) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .slot     (slot),
        .rom_data (rom_data),
        .data_out (data_out)
    );

endmodule

// File: tb/tb_sprite_dma.sv
// Directed bench for sprite_dma with a one-cycle synchronous ROM whose word
// at address a is a[7:0] ^ 8'hA5.
module tb_sprite_dma;

    logic        clk;
    logic        rst_n;
    logic        line_start;
    logic        window;
    logic [3:0]  enable;
    logic [35:0] base;
    logic [35:0] pos;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  dma_avail;
    logic [31:0] data_out;
    logic        busy;
    logic        done;
    logic [2:0]  dbg_state;

    int tests_run;
    int tests_failed;

    logic [3:0]  exp_av[0:15];
    logic [8:0]  exp_ra[0:15];
    logic [31:0] exp_do[0:15];
    logic        exp_do_chk[0:15];
    int          ls_pulse_cyc;
    int          win_drop_cyc;

    sprite_dma #(.NSPR(4), .WIDTH(8), .ADDRW(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .window     (window),
        .enable     (enable),
        .base       (base),
        .pos        (pos),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .dma_avail  (dma_avail),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_addr[7:0] ^ 8'hA5;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 16; i++) begin
            exp_av[i]     = '0;
            exp_ra[i]     = '0;
            exp_do[i]     = '0;
            exp_do_chk[i] = 1'b0;
        end
        ls_pulse_cyc = -1;
        win_drop_cyc = -1;
    endtask

    task automatic start();
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask

    // Checks cycles 1..last after the line_start cycle; done must land on 'last'.
    task automatic seq_check(input string tag, input int last);
        for (int c = 1; c <= last; c++) begin
            check($sformatf("%s avail c%0d", tag, c), 64'(dma_avail), 64'(exp_av[c]));
            check($sformatf("%s addr c%0d", tag, c), 64'(rom_addr), 64'(exp_ra[c]));
            check($sformatf("%s done c%0d", tag, c), 64'(done), 64'(c == last));
            check($sformatf("%s busy c%0d", tag, c), 64'(busy), 64'd1);
            if (exp_do_chk[c])
                check($sformatf("%s data c%0d", tag, c), 64'(data_out), 64'(exp_do[c]));
            line_start = (c == ls_pulse_cyc);
            if (win_drop_cyc > 0 && c >= win_drop_cyc) window = 1'b0;
            step();
        end
        line_start = 1'b0;
        check($sformatf("%s idle busy", tag), 64'(busy), 64'd0);
        check($sformatf("%s idle done", tag), 64'(done), 64'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        line_start   = 1'b1;
        window       = 1'b1;
        enable       = 4'b1111;
        base         = {9'd24, 9'd16, 9'd8, 9'd0};
        pos          = {9'd4, 9'd3, 9'd2, 9'd1};
        clear_exp();

        // Reset held two cycles with line_start asserted
        step();
        step();
        check("rst avail", 64'(dma_avail), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst data", 64'(data_out), 64'd0);
        check("rst addr", 64'(rom_addr), 64'd0);
        line_start = 1'b0;
        rst_n      = 1'b1;
        step();
        check("post rst busy", 64'(busy), 64'd0);

        // Full sequence, with a stray line_start during busy that must be ignored
        clear_exp();
        exp_av[2] = 4'b0001; exp_ra[2] = 9'd1;
        exp_av[5] = 4'b0010; exp_ra[5] = 9'd10;
        exp_av[8] = 4'b0100; exp_ra[8] = 9'd19;
        exp_av[11] = 4'b1000; exp_ra[11] = 9'd28;
        exp_do_chk[3]  = 1'b1; exp_do[3]  = 32'h000000A4;
        exp_do_chk[6]  = 1'b1; exp_do[6]  = 32'h0000AFA4;
        exp_do_chk[9]  = 1'b1; exp_do[9]  = 32'h00B6AFA4;
        exp_do_chk[12] = 1'b1; exp_do[12] = 32'hB9B6AFA4;
        exp_do_chk[13] = 1'b1; exp_do[13] = 32'hB9B6AFA4;
        ls_pulse_cyc = 4;
        start();
        seq_check("full", 13);
        check("full hold", 64'(data_out), 64'hB9B6AFA4);

        // Sparse mask 1010
        clear_exp();
        enable = 4'b1010;
        pos    = {9'd6, 9'd3, 9'd5, 9'd1};
        exp_av[3] = 4'b0010; exp_ra[3] = 9'd13;
        exp_av[7] = 4'b1000; exp_ra[7] = 9'd30;
        exp_do_chk[4] = 1'b1; exp_do[4] = 32'hB9B6A8A4;
        exp_do_chk[8] = 1'b1; exp_do[8] = 32'hBBB6A8A4;
        exp_do_chk[9] = 1'b1; exp_do[9] = 32'hBBB6A8A4;
        start();
        seq_check("sparse", 9);

        // line_start outside the window is ignored
        window = 1'b0;
        start();
        check("nowin busy", 64'(busy), 64'd0);
        step();
        check("nowin busy2", 64'(busy), 64'd0);
        check("nowin done", 64'(done), 64'd0);
        window = 1'b1;

        // Address wrap: 500 + 20 mod 512 = 8; three trailing skips
        clear_exp();
        enable = 4'b0001;
        base   = {9'd24, 9'd16, 9'd8, 9'd500};
        pos    = {9'd6, 9'd3, 9'd5, 9'd20};
        exp_av[2] = 4'b0001; exp_ra[2] = 9'd8;
        exp_do_chk[3] = 1'b1; exp_do[3] = 32'hBBB6A8AD;
        start();
        seq_check("wrap", 7);

        // Window drops in slot 1 GRANT: READ completes, then END
        clear_exp();
        enable = 4'b1111;
        base   = {9'd24, 9'd16, 9'd8, 9'd0};
        pos    = {9'd4, 9'd3, 9'd3, 9'd1};
        exp_av[2] = 4'b0001; exp_ra[2] = 9'd1;
        exp_av[5] = 4'b0010; exp_ra[5] = 9'd11;
        exp_do_chk[3] = 1'b1; exp_do[3] = 32'hBBB6A8A4;
        exp_do_chk[6] = 1'b1; exp_do[6] = 32'hBBB6AEA4;
        win_drop_cyc = 5;
        start();
        seq_check("abort", 7);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort no grant %0d", i), 64'(dma_avail), 64'd0);
            step();
        end
        check("abort hold", 64'(data_out), 64'hBBB6AEA4);
        window = 1'b1;

        // Reset during READ of slot 0: no done, data cleared
        start();
        check("mrst busy c1", 64'(busy), 64'd1);
        step();
        check("mrst avail c2", 64'(dma_avail), 64'd1);
        step();
        check("mrst read data", 64'(data_out), 64'hBBB6AEA4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mrst busy", 64'(busy), 64'd0);
        check("mrst done", 64'(done), 64'd0);
        check("mrst data", 64'(data_out), 64'd0);
        check("mrst avail", 64'(dma_avail), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("mrst no done %0d", i), 64'(done), 64'd0);
            check($sformatf("mrst idle %0d", i), 64'(busy), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sprite_dma.md
SPRITE_DMA -- requirements
Module: sprite_dma

Interface
REQ-001 Parameter NSPR, default 4, is the number of sprite engines served (1..16).
REQ-002 Parameter WIDTH, default 8, is the sprite line width in bits, which equals the ROM data width.
REQ-003 Parameter ADDRW, default 9, is the ROM address width, which equals the sprite pos width.
REQ-004 clk  in  1  is the single system clock; all logic is rising-edge.
REQ-005 rst_n  in  1  is the synchronous, active-low reset.
REQ-006 line_start  in  1  is a one-cycle pulse that begins a DMA sequence for the current line.
REQ-007 window  in  1  is high while DMA is permitted (blanking interval).
REQ-008 enable  in  NSPR  is a per-sprite service mask, sampled at line_start.
REQ-009 base  in  NSPR*ADDRW  is the per-sprite ROM base address (glyph offset), packed with sprite k at [k*ADDRW +: ADDRW].
REQ-010 pos  in  NSPR*ADDRW  is the per-sprite line position from each engine, packed the same way as base.
REQ-011 rom_addr  out  ADDRW  is the synchronous ROM read address (ROM latency 1 cycle).
REQ-012 rom_data  in  WIDTH  is the ROM read data, valid 1 cycle after rom_addr.
REQ-013 dma_avail  out  NSPR  is the one-hot grant to sprite engines.
REQ-014 data_out  out  NSPR*WIDTH  is the per-sprite line data feeding each engine's data_in.
REQ-015 busy  out  1  is high while a sequence is in progress.
REQ-016 done  out  1  is a one-cycle pulse at the end of a sequence, whether completed or aborted.

Function
REQ-017 The block SHALL implement states IDLE, SCAN, GRANT, READ, and END.
REQ-018 In IDLE, on line_start with window=1, the block SHALL latch enable into a mask, set slot=0, and go to SCAN; line_start with window=0 SHALL be ignored.
REQ-019 SCAN SHALL go to GRANT if mask[slot]=1; otherwise it SHALL increment slot, and SHALL go to END when slot=NSPR-1 is skipped. Each skipped slot costs one cycle.
REQ-020 In GRANT, the block SHALL hold dma_avail[slot]=1, with all other bits 0, and rom_addr=base[slot]+pos[slot] (ADDRW-bit modulo sum, wrap-around allowed). GRANT SHALL last exactly 1 cycle and then go to READ.
REQ-021 In READ, data_out[slot] SHALL equal rom_data combinationally, and the block SHALL register rom_data into hold[slot] at the end of the cycle. The engine samples in this cycle, so grant-to-data latency is exactly 1 cycle.
REQ-022 Outside READ, or for any k other than the current slot, data_out[k] SHALL equal hold[k].
REQ-023 After READ, the block SHALL go to END if slot=NSPR-1 or window=0; otherwise it SHALL increment slot and go to SCAN.
REQ-024 If window falls during SCAN, the block SHALL go directly to END. If window falls during GRANT, the block SHALL still complete READ (no torn transfer) and then go to END.
REQ-025 END SHALL assert done for 1 cycle and return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 line_start arriving while busy=1 SHALL be ignored, with no restart.
REQ-028 rom_addr SHALL be 0 outside GRANT, and dma_avail SHALL be 0 outside GRANT.
REQ-029 The cycle cost SHALL be, for E enabled and S skipped sprites, 3*E + S + 1 cycles from line_start to done, counting END.

Reset
REQ-030 While rst_n=0 at a clock edge, the block SHALL set state=IDLE, slot=0, mask=0, all hold registers=0, dma_avail=0, rom_addr=0, busy=0, and done=0.
REQ-031 Reset mid-sequence SHALL abort immediately with no done pulse, and data_out SHALL read 0 on the following cycle.

Structure
REQ-032 The state enum shall be sprite_dma_state_t in the shared package gfx_pkg, alongside a ROM-latency constant ROM_LAT=1.
REQ-033 The per-slot hold registers and the data_out mux shall be one sub-module, sprite_dma_hold, instantiated once with NSPR entries.

Verification
REQ-034 Reset: hold rst_n=0 for 2 cycles with line_start=1 -> dma_avail=0, busy=0, done=0, and all data_out=0.
REQ-035 Full sequence: NSPR=4, enable=4'b1111, window=1, base={0,8,16,24}, pos={1,2,3,4} -> grants 0001/0010/0100/1000 at cycles 2/5/8/11 after line_start, rom_addr=1/10/19/28, and done at cycle 13.
REQ-036 Sparse mask: enable=4'b1010 -> only dma_avail bits 1 and 3 pulse, and done arrives 3*2+2+1=9 cycles after line_start.
REQ-037 Wrap-around: ADDRW=9, base=500, pos=20 -> rom_addr=8.
REQ-038 Abort: window drops in the GRANT cycle of slot 1 -> slot 1 READ completes and hold[1] updates, slots 2-3 receive no grant, and done pulses the next cycle.
REQ-039 Mid-operation: line_start during busy is ignored; rst_n=0 during READ produces no done pulse, and data_out=0 the next cycle.
